// File: rtl/branch_predictor_table_pkg.sv
// Shared definitions for the branch history table: named 2-bit counter states and
// the width-generic saturating next-counter function used by the table and its bypass.
package branch_predictor_table_pkg;

    localparam int CTR_MAX_W = 8;

    localparam logic [1:0] CTR_SNT = 2'b00;
    localparam logic [1:0] CTR_WNT = 2'b01;
    localparam logic [1:0] CTR_WT  = 2'b10;
    localparam logic [1:0] CTR_ST  = 2'b11;

    // Counter travels zero-extended to CTR_MAX_W bits; width selects the saturation ceiling.
    function automatic logic [CTR_MAX_W-1:0] sat_update(
        input logic [CTR_MAX_W-1:0] ctr,
        input logic                 taken,
        input int                   width
    );
        logic [CTR_MAX_W-1:0] top;
        top = CTR_MAX_W'((1 << width) - 1);
        if (taken) begin
            sat_update = (ctr == top) ? ctr : ctr + CTR_MAX_W'(1);
        end else begin
            sat_update = (ctr == '0) ? ctr : ctr - CTR_MAX_W'(1);
        end
    endfunction

    function automatic logic ctr_msb(
        input logic [CTR_MAX_W-1:0] ctr,
        input int                   width
    );
        logic [CTR_MAX_W-1:0] shifted;
        shifted = ctr >> (width - 1);
        return shifted[0];
    endfunction

endpackage

// File: rtl/branch_predictor_table_sat_counter.sv
// One table entry: CTR_WIDTH-bit saturating up/down counter, moved only on its
// decoded write strobe, asynchronously reset to INIT_CTR.
module bpt_sat_counter
    import branch_predictor_table_pkg::*;
#(
    parameter int CTR_WIDTH = 2,
    parameter int INIT_CTR  = 1
) (
    input  logic                 i_clk,
    input  logic                 i_arst,
    input  logic                 i_we,
    input  logic                 i_taken,
    output logic [CTR_WIDTH-1:0] o_ctr
);

    logic [CTR_WIDTH-1:0] r_ctr;

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            r_ctr <= CTR_WIDTH'(INIT_CTR);
        end else if (i_we) begin
            r_ctr <= CTR_WIDTH'(sat_update(CTR_MAX_W'(r_ctr), i_taken, CTR_WIDTH));
        end
    end

    assign o_ctr = r_ctr;

endmodule

// File: rtl/branch_predictor_table.sv
// Branch history table of saturating counters: bimodal or gshare indexing, registered
// prediction one cycle after lookup, training from execute every cycle regardless of stall.
module branch_predictor_table
    import branch_predictor_table_pkg::*;
#(
    parameter int INDEX_BITS = 5,
    parameter int CTR_WIDTH  = 2,
    parameter int INIT_CTR   = 1,
    parameter int GSHARE     = 0,
    parameter int GHR_BITS   = 5
) (
    input  logic                  i_clk,
    input  logic                  i_arst,
    input  logic                  i_en,
    input  logic [INDEX_BITS-1:0] i_rd_addr,
    output logic                  o_prediction,
    output logic [INDEX_BITS-1:0] o_pred_index,
    input  logic                  i_upd_valid,
    input  logic [INDEX_BITS-1:0] i_upd_index,
    input  logic                  i_upd_taken
);

    localparam int DEPTH = 1 << INDEX_BITS;

    logic [INDEX_BITS-1:0] w_ghr_ext;
    logic [INDEX_BITS-1:0] w_idx;
    logic [DEPTH-1:0]      w_we;
    logic [CTR_WIDTH-1:0]  w_ctr [DEPTH];
    logic [CTR_WIDTH-1:0]  w_rd_ctr;
    logic [CTR_MAX_W-1:0]  w_rd_post;
    logic                  w_collide;
    logic                  w_rd_pred;

    logic                  r_prediction;
    logic [INDEX_BITS-1:0] r_pred_index;

    // History is updated only by resolved branches, so it never needs repair.
    generate
        if (GSHARE != 0) begin : g_gshare
            logic [GHR_BITS-1:0] r_ghr;

            always_ff @(posedge i_clk or posedge i_arst) begin
                if (i_arst) begin
                    r_ghr <= '0;
                end else if (i_upd_valid) begin
                    r_ghr <= GHR_BITS'({r_ghr, i_upd_taken});
                end
            end

            assign w_ghr_ext = INDEX_BITS'(r_ghr);
        end else begin : g_bimodal
            assign w_ghr_ext = '0;
        end
    endgenerate

    assign w_idx = i_rd_addr ^ w_ghr_ext;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            assign w_we[gi] = i_upd_valid && (i_upd_index == INDEX_BITS'(gi));

            bpt_sat_counter #(
                .CTR_WIDTH (CTR_WIDTH),
                .INIT_CTR  (INIT_CTR)
            ) u_ctr (
                .i_clk   (i_clk),
                .i_arst  (i_arst),
                .i_we    (w_we[gi]),
                .i_taken (i_upd_taken),
                .o_ctr   (w_ctr[gi])
            );
        end
    endgenerate

    // Write-first: a lookup hitting the entry being trained sees the trained value.
    assign w_rd_ctr  = w_ctr[w_idx];
    assign w_collide = i_upd_valid && (i_upd_index == w_idx);
    assign w_rd_post = w_collide ? sat_update(CTR_MAX_W'(w_rd_ctr), i_upd_taken, CTR_WIDTH)
                                 : CTR_MAX_W'(w_rd_ctr);
    assign w_rd_pred = ctr_msb(w_rd_post, CTR_WIDTH);

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            r_prediction <= 1'b0;
            r_pred_index <= '0;
        end else if (i_en) begin
            r_prediction <= w_rd_pred;
            r_pred_index <= w_idx;
        end
    end

    assign o_prediction = r_prediction;
    assign o_pred_index = r_pred_index;

endmodule
